inst_fetch: RTL and testbench

Instruction fetch unit: the requesting end of the instruction ROM port. It owns the program counter, drives chip-enable and address to the registered-output instruction ROM (1-cycle read latency), and aligns each returned instruction with the PC that fetched it. It presents one instruction per cycle to the IF/ID register, honouring pipeline stall, branch redirect (with delay-slot semantics) and flush from the control unit.

---
 rtl/inst_fetch.sv | 105 ++++++++++
 tb/tb_inst_fetch.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues reads to a 1-cycle-latency ROM and
// presents each returned instruction with the PC that fetched it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_reg, pc_next;
  logic        running_reg, running_next;
  logic        req_valid_reg, req_valid_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic        hold_valid_reg, hold_valid_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] hold_inst_reg, hold_inst_next;
  logic        branch_take;

  assign rom_ce_o    = running_reg & ~stall_i & ~flush_i;
  assign rom_addr_o  = pc_reg;
  assign branch_take = branch_flag_i & ~stall_i & ~flush_i;
  assign if_valid_o  = (hold_valid_reg | req_valid_reg) & ~flush_i;

  // The stall buffer takes precedence: it holds the older instruction.
  always_comb begin
    if_pc_o   = 32'h0000_0000;
    if_inst_o = ZERO_WORD;
    if (if_valid_o) begin
      if (hold_valid_reg) begin
        if_pc_o   = hold_pc_reg;
        if_inst_o = hold_inst_reg;
      end else begin
        if_pc_o   = req_pc_reg;
        if_inst_o = rom_inst_i;
      end
    end
  end

  always_comb begin
    pc_next         = pc_reg;
    running_next    = 1'b1;
    req_valid_next  = 1'b0;
    req_pc_next     = req_pc_reg;
    hold_valid_next = hold_valid_reg;
    hold_pc_next    = hold_pc_reg;
    hold_inst_next  = hold_inst_reg;
    if (flush_i) begin
      pc_next         = {new_pc_i[31:2], 2'b00};
      hold_valid_next = 1'b0;
    end else if (branch_take) begin
      // The instruction presented now is the delay slot and is consumed;
      // the sequential request this cycle is dropped in favour of the target.
      pc_next         = {branch_target_addr_i[31:2], 2'b00};
      hold_valid_next = 1'b0;
    end else if (stall_i) begin
      if (req_valid_reg && !hold_valid_reg) begin
        hold_valid_next = 1'b1;
        hold_pc_next    = req_pc_reg;
        hold_inst_next  = rom_inst_i;
      end
    end else begin
      hold_valid_next = 1'b0;
      if (rom_ce_o) begin
        req_valid_next = 1'b1;
        req_pc_next    = pc_reg;
        pc_next        = pc_reg + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg         <= RESET_PC_ALIGNED;
      running_reg    <= 1'b0;
      req_valid_reg  <= 1'b0;
      req_pc_reg     <= 32'h0000_0000;
      hold_valid_reg <= 1'b0;
      hold_pc_reg    <= 32'h0000_0000;
      hold_inst_reg  <= ZERO_WORD;
    end else begin
      pc_reg         <= pc_next;
      running_reg    <= running_next;
      req_valid_reg  <= req_valid_next;
      req_pc_reg     <= req_pc_next;
      hold_valid_reg <= hold_valid_next;
      hold_pc_reg    <= hold_pc_next;
      hold_inst_reg  <= hold_inst_next;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Cycle-by-cycle vector table for inst_fetch against a behavioural ROM
// (word i holds i+0x100); presented PCs are checked through a scoreboard queue.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, branch_flag_i;
  logic [31:0] new_pc_i, branch_target_addr_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic [31:0] if_pc_o, if_inst_o;
  logic        if_valid_o;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_i              (stall_i),
    .flush_i              (flush_i),
    .new_pc_i             (new_pc_i),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .rom_ce_o             (rom_ce_o),
    .rom_addr_o           (rom_addr_o),
    .rom_inst_i           (rom_inst_i),
    .if_pc_o              (if_pc_o),
    .if_inst_o            (if_inst_o),
    .if_valid_o           (if_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr >> 2) + 32'h100;
  endfunction

  // Registered-output ROM; returns zero when not enabled so a missed capture shows up.
  always @(posedge clk) rom_inst_i <= rom_ce_o ? mem_word(rom_addr_o) : 32'h0;

  typedef struct {
    logic        rst, stall, flush, br;
    logic [31:0] tgt, npc;
    logic        chk, ev;
    logic [31:0] epc;
    logic        ece;
    logic [31:0] eaddr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic vec_t mk(input logic r, s, f, b, input logic [31:0] tgt, npc,
                              input logic chk, ev, input logic [31:0] epc,
                              input logic ece, input logic [31:0] eaddr);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.br = b; v.tgt = tgt; v.npc = npc;
    v.chk = chk; v.ev = ev; v.epc = epc; v.ece = ece; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [31:0] e;
    //                 rst st fl br target        new_pc       chk ev exp_pc       ce addr
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h0,        1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h4,        1, 32'h8));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,       1, 1, 32'h8,        0, 32'hC));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,       1, 1, 32'h8,        0, 32'hC));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,       1, 1, 32'h8,        0, 32'hC));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h8,        1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'hC,        1, 32'h10));
    vecs.push_back(mk(0, 0, 0, 1, 32'h40,       32'h0,       1, 1, 32'h10,       1, 32'h14));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 32'h40));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h40,       1, 32'h44));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h44,       1, 32'h48));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,       1, 1, 32'h48,       0, 32'h4C));
    vecs.push_back(mk(0, 1, 1, 1, 32'h200,      32'h180,     1, 0, 32'h0,        0, 32'h4C));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 32'h180));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h180,      1, 32'h184));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h184,      1, 32'h188));
    vecs.push_back(mk(0, 1, 0, 1, 32'hFFFFFFFE, 32'h0,       1, 1, 32'h188,      0, 32'h18C));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFFFFFE, 32'h0,       1, 1, 32'h188,      1, 32'h18C));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'hFFFFFFFC, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h0,        1, 32'h4));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,       1, 1, 32'h4,        0, 32'h8));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,       1, 1, 32'h4,        0, 32'h8));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h0,       0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 0, 32'h0,        1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h0,        1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,       1, 1, 32'h4,        1, 32'h8));

    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
    new_pc_i = 32'h0; branch_target_addr_i = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stall_i = vecs[i].stall; flush_i = vecs[i].flush;
      branch_flag_i = vecs[i].br; branch_target_addr_i = vecs[i].tgt;
      new_pc_i = vecs[i].npc;
      if (vecs[i].ev) exp_q.push_back(vecs[i].epc);
      @(negedge clk);
      $display("vec %0d rst=%0b stall=%0b flush=%0b br=%0b | ce=%0b addr=%h valid=%0b pc=%h inst=%h",
               i, rst, stall_i, flush_i, branch_flag_i, rom_ce_o, rom_addr_o,
               if_valid_o, if_pc_o, if_inst_o);
      if (vecs[i].chk) begin
        check("valid", i, {31'b0, if_valid_o}, {31'b0, vecs[i].ev});
        check("rom_ce", i, {31'b0, rom_ce_o}, {31'b0, vecs[i].ece});
        check("rom_addr", i, rom_addr_o, vecs[i].eaddr);
        if (if_valid_o) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow vec %0d: got pc %h want no instruction", i, if_pc_o);
          end else begin
            e = exp_q.pop_front();
            check("if_pc", i, if_pc_o, e);
            check("if_inst", i, if_inst_o, mem_word(e));
          end
        end else begin
          check("idle_pc", i, if_pc_o, 32'h0);
          check("idle_inst", i, if_inst_o, 32'h0);
        end
      end
      @(posedge clk); #1;
    end

    check("sb_drain", vecs.size(), exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
